// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp: slew-limited PWM drive for one H-bridge motor.
// Ramps duty toward the requested speed, decelerates to zero before reversing.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   real_speed   requested magnitude (saturated to PWM range)
//   direction    requested direction (1 = reverse)
//   enable       0 stops the motor immediately
//   pwm_out      registered PWM to the bridge
//   motor_dir    applied direction, changes only at zero duty
//   cur_duty     current ramped duty
//   at_target    RUN and duty equals the requested duty
//   state        0 IDLE, 1 RUN, 2 DECEL

module motor_pwm_ramp #(
  parameter int WIDTH    = 32,
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 16,
  parameter int STEP     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    real_speed,
  input  logic                direction,
  input  logic                enable,
  output logic                pwm_out,
  output logic                motor_dir,
  output logic [PWM_BITS-1:0] cur_duty,
  output logic                at_target,
  output logic [1:0]          state
);

  localparam int PW =
    (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAXD = '1;

  localparam logic [PWM_BITS-1:0] STEP_D =
    PWM_BITS'(STEP);

  localparam logic [PW-1:0] PRE_TOP =
    PW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DECEL = 2'd2
  } st_t;

  st_t st;

  logic [PWM_BITS-1:0] tgt;
  logic                dir_req;
  logic                en_r;

  logic [PW-1:0]       pre;
  logic                tick;

  logic [PWM_BITS-1:0] gap_up;
  logic [PWM_BITS-1:0] gap_dn;
  logic [PWM_BITS-1:0] ramp_duty;
  logic [PWM_BITS-1:0] dec_duty;

  logic [PWM_BITS-1:0] pcnt;
  logic [PWM_BITS-1:0] act_duty;
  logic                pwm_off;

  assign state = st;

  // Input registers; speed saturates to the PWM range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt     <= '0;
      dir_req <= 1'b0;
      en_r    <= 1'b0;
    end else begin
      if (real_speed > WIDTH'(MAXD))
        tgt <= MAXD;
      else
        tgt <= real_speed[PWM_BITS-1:0];
      dir_req <= direction;
      en_r    <= enable;
    end
  end

  // Ramp prescaler, parked at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre <= '0;
    else if (st == IDLE || !en_r)
      pre <= '0;
    else if (pre == PRE_TOP)
      pre <= '0;
    else
      pre <= pre + PW'(1);
  end

  assign tick = (st != IDLE) && (pre == PRE_TOP);

  assign gap_up = tgt - cur_duty;
  assign gap_dn = cur_duty - tgt;

  // Next duty one step toward tgt, never overshooting.
  always_comb begin
    ramp_duty = cur_duty;
    if (tgt > cur_duty) begin
      if (gap_up < STEP_D)
        ramp_duty = tgt;
      else
        ramp_duty = cur_duty + STEP_D;
    end else if (tgt < cur_duty) begin
      if (gap_dn < STEP_D)
        ramp_duty = tgt;
      else
        ramp_duty = cur_duty - STEP_D;
    end
  end

  assign dec_duty =
    (cur_duty < STEP_D) ? '0 : cur_duty - STEP_D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cur_duty  <= '0;
      motor_dir <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          cur_duty <= '0;
          if (en_r) begin
            motor_dir <= dir_req;
            st        <= RUN;
          end
        end
        RUN: begin
          if (!en_r) begin
            st       <= IDLE;
            cur_duty <= '0;
          end else if (dir_req != motor_dir) begin
            st <= DECEL;
          end else if (tick) begin
            cur_duty <= ramp_duty;
          end
        end
        DECEL: begin
          if (!en_r) begin
            st       <= IDLE;
            cur_duty <= '0;
          end else if (dir_req == motor_dir) begin
            st <= RUN;
          end else if (cur_duty == '0) begin
            // Bridge is fully off: safe to flip.
            motor_dir <= dir_req;
            st        <= RUN;
          end else if (tick) begin
            cur_duty <= dec_duty;
          end
        end
        default: begin
          st       <= IDLE;
          cur_duty <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      at_target <= 1'b0;
    else
      at_target <= (st == RUN) && (cur_duty == tgt);
  end

  assign pwm_off = !en_r || (st == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcnt <= '0;
    else
      pcnt <= pcnt + PWM_BITS'(1);
  end

  // Duty latched at period end; a stop cuts it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_duty <= '0;
      pwm_out  <= 1'b0;
    end else if (pwm_off) begin
      act_duty <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (pcnt == MAXD)
        act_duty <= cur_duty;
      pwm_out <= (pcnt < act_duty);
    end
  end

endmodule

// File: doc/motor_pwm_ramp.md
Name: motor_pwm_ramp

Overview:
- Sits directly downstream of the binary-to-real speed converter and drives one drive-motor H-bridge.
- Consumes the converter's real_speed magnitude and direction bit and produces a PWM waveform plus a direction line.
- Slew-limits the duty cycle to a programmable ramp rate, so speed steps from the converter never reach the motor as current spikes.
- Forces ramp-to-zero before any direction reversal.

Parameters:
WIDTH, 32, width of real_speed input (matches converter output)
PWM_BITS, 8, PWM counter/duty width; period = 2^PWM_BITS clk cycles
RAMP_DIV, 16, clk cycles between ramp updates (>=1)
STEP, 8, duty change per ramp update (1..2^PWM_BITS-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
real_speed  input  WIDTH  requested speed magnitude from converter
direction  input  1  requested direction from converter (1 = reverse)
enable  input  1  motor enable; 0 = stop immediately
pwm_out  output  1  PWM to H-bridge
motor_dir  output  1  applied direction to H-bridge
cur_duty  output  PWM_BITS  current ramped duty
at_target  output  1  ramp has reached requested duty
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 DECEL

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0: pwm_out, motor_dir, cur_duty, at_target, state=IDLE. Also clears the PWM counter, prescaler, active duty, and input registers.
- Input stage, every cycle:
  - tgt <= (real_speed > 2^PWM_BITS-1) ? 2^PWM_BITS-1 : real_speed[PWM_BITS-1:0] (saturating).
  - dir_req <= direction; en_r <= enable.
  - All decisions use these registered copies (1-cycle input latency).
- Prescaler:
  - Counts 0..RAMP_DIV-1 in RUN/DECEL; tick asserted for one cycle when count == RAMP_DIV-1, then wraps to 0.
  - Held at 0 in IDLE, so the first tick comes RAMP_DIV cycles after entering RUN.
- FSM:
  - IDLE: cur_duty=0. If en_r=1, load motor_dir <= dir_req and go to RUN.
  - RUN:
    - If en_r=0, go to IDLE with cur_duty <= 0 in the same cycle.
    - Else if dir_req != motor_dir, go to DECEL.
    - Else on tick: cur_duty moves toward tgt by STEP, clamped so it never overshoots (|tgt-cur_duty| < STEP ⇒ cur_duty <= tgt).
  - DECEL:
    - If en_r=0, go to IDLE (cur_duty <= 0).
    - Else on tick: cur_duty <= max(cur_duty-STEP, 0).
    - When cur_duty==0 (registered value): motor_dir <= dir_req, go to RUN.
    - If dir_req returns to motor_dir before zero, go back to RUN without changing motor_dir.
- motor_dir only changes in IDLE→RUN or DECEL→RUN, and only when cur_duty==0. It never toggles while pwm_out can be high.
- at_target = (state==RUN) && (cur_duty==tgt), registered.
- PWM generation:
  - Counter pcnt runs 0..2^PWM_BITS-1 continuously and wraps.
  - Active duty latched from cur_duty when pcnt == 2^PWM_BITS-1, so it takes effect at pcnt==0. This avoids mid-period glitches.
  - pwm_out (registered) = (pcnt < active_duty). Duty 0 gives constant low; max duty gives 2^PWM_BITS-1 high cycles per period.
  - Exception: on en_r=0 or state==IDLE, active_duty is cleared and pwm_out goes low on the next edge, without waiting for the period boundary.
- Simultaneous events:
  - en_r=0 has priority over direction mismatch and over tick.
  - A tick and a direction mismatch in the same RUN cycle: take the transition; no duty change that cycle.
- tgt changes mid-ramp: ramp re-aims at the new tgt on the next tick; no restart of the prescaler.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-PWM with duty 128 → all outputs 0 asynchronously, before the next clk edge; release with enable=0 → state stays 0, pwm_out stays 0.
2. Ramp up (STEP=8, RAMP_DIV=16): enable=1, direction=0, real_speed=64 → cur_duty goes 8,16,…,64 at 16-cycle intervals; at_target=1 after the 8th tick; then pwm_out is high exactly 64 of every 256 cycles.
3. Saturation/clamp: real_speed=1000 → tgt=255; cur_duty goes …,240,248,255 (last step clamped); at_target=1; pwm_out high 255/256.
4. Reversal: from steady duty 64, direction=1 → state=2; cur_duty goes 56…0 over 8 ticks; motor_dir flips to 1 only with cur_duty==0; then ramps to 64 in RUN.
5. Enable drop mid-ramp (cur_duty=40): enable=0 → state=0 and cur_duty=0 after the input-register edge; pwm_out low by the following edge; motor_dir unchanged.
6. Reversal aborted: in DECEL at cur_duty=32, direction returns to 0 → state=1, motor_dir stays 0, ramp back up to tgt.
